// File: rtl/multicycle_sequencer_if.sv
// Bus bundle between the multi-cycle sequencer and the instruction memory,
// data memory and datapath control inputs. The master side is the sequencer.
interface multicycle_sequencer_if #(
  parameter int PC_W = 16
);

  // Instruction side
  logic [PC_W-1:0] pc;
  logic            imem_req;
  logic            imem_ready;
  logic            ir_load;
  logic [3:0]      op;

  // Data memory side
  logic            dmem_ready;

  // Datapath control
  logic            ALUSrc;
  logic            MR;
  logic            MW;
  logic            MReg;
  logic            EnRW;
  logic [1:0]      ALUOp;

  modport master (
    output pc, imem_req, ir_load, ALUSrc, MR, MW, MReg, EnRW, ALUOp,
    input  imem_ready, op, dmem_ready
  );

  modport slave (
    input  pc, imem_req, ir_load, ALUSrc, MR, MW, MReg, EnRW, ALUOp,
    output imem_ready, op, dmem_ready
  );

endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 4-bit-opcode RISC core.
// Walks FETCH -> DECODE -> EXEC -> WB (or MEM for stores), owns the PC and
// drives the datapath strobes so write enables appear only in their own cycle.
// The only combinational input-to-output path is ir_load, which is the fetch
// handshake strobe itself; every other output comes from registered state.
module multicycle_sequencer #(
  parameter int PC_W        = 16,
  parameter int PC_STEP     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  multicycle_sequencer_if.master bus,
  output logic                   busy,
  output logic                   illegal,
  output logic                   mem_timeout
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [PC_W-1:0] PC_INC   = PC_W'(PC_STEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SW    = 4'b0111;
  localparam logic [3:0] OP_NANDI = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic             imem_req_c;
  logic             ir_load_c;
  logic             alu_src_c;
  logic             mw_c;
  logic             mreg_c;
  logic             en_rw_c;
  logic [1:0]       alu_op_c;

  function automatic logic is_legal(input logic [3:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_OR) ||
           (code == OP_SW)  || (code == OP_NANDI);
  endfunction

  // State, PC, latched opcode, MEM wait counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic; run is only consulted at instruction boundaries
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = bus.op;
        if (is_legal(bus.op)) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          pc_d      = pc_q + PC_INC;
          state_d   = run ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC: begin
        if (op_q == OP_SW) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = pc_q + PC_INC;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          pc_d    = pc_q + PC_INC;
          state_d = run ? S_FETCH : S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          pc_d      = pc_q + PC_INC;
          state_d   = run ? S_FETCH : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control strobes decoded from the current state and the latched opcode
  always_comb begin
    imem_req_c = 1'b0;
    ir_load_c  = 1'b0;
    alu_src_c  = 1'b0;
    mw_c       = 1'b0;
    mreg_c     = 1'b0;
    en_rw_c    = 1'b0;
    alu_op_c   = 2'b00;
    if (state_q == S_FETCH) begin
      imem_req_c = 1'b1;
      ir_load_c  = bus.imem_ready;
    end
    if (state_q == S_MEM) mw_c = 1'b1;
    if (state_q == S_WB)  en_rw_c = 1'b1;
    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      case (op_q)
        OP_ADD:   begin alu_op_c = 2'b00; alu_src_c = 1'b0; mreg_c = 1'b1; end
        OP_SUB:   begin alu_op_c = 2'b01; alu_src_c = 1'b0; mreg_c = 1'b1; end
        OP_OR:    begin alu_op_c = 2'b10; alu_src_c = 1'b0; mreg_c = 1'b1; end
        OP_SW:    begin alu_op_c = 2'b00; alu_src_c = 1'b1; mreg_c = 1'b0; end
        OP_NANDI: begin alu_op_c = 2'b11; alu_src_c = 1'b1; mreg_c = 1'b0; end
        default:  begin alu_op_c = 2'b00; alu_src_c = 1'b0; mreg_c = 1'b0; end
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.imem_req = imem_req_c;
  assign bus.ir_load  = ir_load_c;
  assign bus.ALUSrc   = alu_src_c;
  assign bus.MR       = 1'b0;
  assign bus.MW       = mw_c;
  assign bus.MReg     = mreg_c;
  assign bus.EnRW     = en_rw_c;
  assign bus.ALUOp    = alu_op_c;

  assign busy        = (state_q != S_IDLE);
  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a table of per-cycle vectors for the
// ALU instruction stream plus hand-written store, timeout, illegal, run and
// reset/wrap sequences. Inputs change 2 time units after the rising edge and
// outputs are compared 1 unit later.
module tb_multicycle_sequencer;

  logic clk;
  logic rst;
  logic run;
  logic busy;
  logic illegal;
  logic mem_timeout;

  int checks;
  int passed;

  multicycle_sequencer_if #(.PC_W(16)) bus ();

  multicycle_sequencer #(
    .PC_W(16),
    .PC_STEP(4),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .bus(bus),
    .busy(busy),
    .illegal(illegal),
    .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic        imem_req;
    logic        ir_load;
    logic        alu_src;
    logic        mr;
    logic        mw;
    logic        mreg;
    logic        en_rw;
    logic [1:0]  alu_op;
    logic        busy;
    logic        illegal;
    logic        mem_timeout;
  } exp_t;

  typedef struct {
    string      name;
    logic       run;
    logic       imem_ready;
    logic [3:0] op;
    logic       dmem_ready;
    exp_t       exp;
  } vec_t;

  function automatic exp_t o(input logic [15:0] pc, input logic req, input logic irl,
                             input logic src, input logic mw, input logic mreg,
                             input logic en, input logic [1:0] aop, input logic bsy,
                             input logic ill, input logic mto);
    exp_t e;
    e.pc = pc; e.imem_req = req; e.ir_load = irl; e.alu_src = src; e.mr = 1'b0;
    e.mw = mw; e.mreg = mreg; e.en_rw = en; e.alu_op = aop; e.busy = bsy;
    e.illegal = ill; e.mem_timeout = mto;
    return e;
  endfunction

  task automatic applyStimulus(input logic r, input logic ir, input logic [3:0] opc,
                               input logic dr);
    run            = r;
    bus.imem_ready = ir;
    bus.op         = opc;
    bus.dmem_ready = dr;
  endtask

  task automatic checkOutput(input string name, input exp_t exp);
    exp_t act;
    act.pc = bus.pc; act.imem_req = bus.imem_req; act.ir_load = bus.ir_load;
    act.alu_src = bus.ALUSrc; act.mr = bus.MR; act.mw = bus.MW; act.mreg = bus.MReg;
    act.en_rw = bus.EnRW; act.alu_op = bus.ALUOp; act.busy = busy;
    act.illegal = illegal; act.mem_timeout = mem_timeout;
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got pc=%h flags=%b, want pc=%h flags=%b",
               name, act.pc, act[11:0], exp.pc, exp[11:0]);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step(input string name, input logic r, input logic ir,
                      input logic [3:0] opc, input logic dr, input exp_t exp);
    applyStimulus(r, ir, opc, dr);
    #1;
    checkOutput(name, exp);
    tick();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  vec_t stream[$];
  exp_t e0;

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);

    // ALU stream: ADD, SUB, OR, NANDI at pc 0,4,8,12; op is junk outside DECODE
    //                  pc   req irl src mw mreg en aop  bsy ill mto
    stream.push_back('{"idle",        1, 1, 4'b0101, 0, o(16'd0, 0,0,0,0,0,0,2'b00,0,0,0)});
    stream.push_back('{"add_fetch",   1, 1, 4'b0101, 0, o(16'd0, 1,1,0,0,0,0,2'b00,1,0,0)});
    stream.push_back('{"add_decode",  1, 1, 4'b0000, 0, o(16'd0, 0,0,0,0,0,0,2'b00,1,0,0)});
    stream.push_back('{"add_exec",    1, 1, 4'b0101, 0, o(16'd0, 0,0,0,0,1,0,2'b00,1,0,0)});
    stream.push_back('{"add_wb",      1, 1, 4'b0101, 0, o(16'd0, 0,0,0,0,1,1,2'b00,1,0,0)});
    stream.push_back('{"sub_fetch",   1, 1, 4'b0101, 0, o(16'd4, 1,1,0,0,0,0,2'b00,1,0,0)});
    stream.push_back('{"sub_decode",  1, 1, 4'b0001, 0, o(16'd4, 0,0,0,0,0,0,2'b00,1,0,0)});
    stream.push_back('{"sub_exec",    1, 1, 4'b0101, 0, o(16'd4, 0,0,0,0,1,0,2'b01,1,0,0)});
    stream.push_back('{"sub_wb",      1, 1, 4'b0101, 0, o(16'd4, 0,0,0,0,1,1,2'b01,1,0,0)});
    stream.push_back('{"or_fetch",    1, 1, 4'b0101, 0, o(16'd8, 1,1,0,0,0,0,2'b00,1,0,0)});
    stream.push_back('{"or_decode",   1, 1, 4'b0011, 0, o(16'd8, 0,0,0,0,0,0,2'b00,1,0,0)});
    stream.push_back('{"or_exec",     1, 1, 4'b0101, 0, o(16'd8, 0,0,0,0,1,0,2'b10,1,0,0)});
    stream.push_back('{"or_wb",       1, 1, 4'b0101, 0, o(16'd8, 0,0,0,0,1,1,2'b10,1,0,0)});
    stream.push_back('{"nandi_fetch", 1, 1, 4'b0101, 0, o(16'd12,1,1,0,0,0,0,2'b00,1,0,0)});
    stream.push_back('{"nandi_decode",1, 1, 4'b1111, 0, o(16'd12,0,0,0,0,0,0,2'b00,1,0,0)});
    stream.push_back('{"nandi_exec",  1, 1, 4'b0101, 0, o(16'd12,0,0,1,0,0,0,2'b11,1,0,0)});
    stream.push_back('{"nandi_wb",    1, 1, 4'b0101, 0, o(16'd12,0,0,1,0,0,1,2'b11,1,0,0)});
    stream.push_back('{"stream_end",  1, 0, 4'b0101, 0, o(16'd16,1,0,0,0,0,0,2'b00,1,0,0)});

    doReset();
    for (int i = 0; i < stream.size(); i++)
      step(stream[i].name, stream[i].run, stream[i].imem_ready, stream[i].op,
           stream[i].dmem_ready, stream[i].exp);

    // Store acknowledged in its third MEM cycle
    doReset();
    step("sw_idle",   1, 1, 4'b0000, 0, o(16'd0, 0,0,0,0,0,0,2'b00,0,0,0));
    step("sw_fetch",  1, 1, 4'b0000, 0, o(16'd0, 1,1,0,0,0,0,2'b00,1,0,0));
    step("sw_decode", 1, 1, 4'b0111, 0, o(16'd0, 0,0,0,0,0,0,2'b00,1,0,0));
    step("sw_exec",   1, 1, 4'b0000, 0, o(16'd0, 0,0,1,0,0,0,2'b00,1,0,0));
    step("sw_mem1",   1, 1, 4'b0000, 0, o(16'd0, 0,0,1,1,0,0,2'b00,1,0,0));
    step("sw_mem2",   1, 1, 4'b0000, 0, o(16'd0, 0,0,1,1,0,0,2'b00,1,0,0));
    step("sw_mem3",   1, 1, 4'b0000, 1, o(16'd0, 0,0,1,1,0,0,2'b00,1,0,0));
    step("sw_after",  1, 0, 4'b0000, 1, o(16'd4, 1,0,0,0,0,0,2'b00,1,0,0));

    // Store never acknowledged: 15 MEM cycles, then sticky timeout
    doReset();
    step("to_idle",   1, 1, 4'b0000, 0, o(16'd0, 0,0,0,0,0,0,2'b00,0,0,0));
    step("to_fetch",  1, 1, 4'b0000, 0, o(16'd0, 1,1,0,0,0,0,2'b00,1,0,0));
    step("to_decode", 1, 1, 4'b0111, 0, o(16'd0, 0,0,0,0,0,0,2'b00,1,0,0));
    step("to_exec",   1, 1, 4'b0000, 0, o(16'd0, 0,0,1,0,0,0,2'b00,1,0,0));
    for (int c = 0; c < 15; c++)
      step($sformatf("to_mem%0d", c + 1), 1, 1, 4'b0000, 0,
           o(16'd0, 0,0,1,1,0,0,2'b00,1,0,0));
    step("to_fetch2",  1, 1, 4'b0000, 0, o(16'd4, 1,1,0,0,0,0,2'b00,1,0,1));
    step("to_decode2", 1, 1, 4'b0000, 0, o(16'd4, 0,0,0,0,0,0,2'b00,1,0,1));
    step("to_exec2",   1, 1, 4'b0000, 0, o(16'd4, 0,0,0,0,1,0,2'b00,1,0,1));
    step("to_wb2",     1, 1, 4'b0000, 0, o(16'd4, 0,0,0,0,1,1,2'b00,1,0,1));
    step("to_fetch3",  1, 1, 4'b0000, 0, o(16'd8, 1,1,0,0,0,0,2'b00,1,0,1));
    step("to_decode3", 1, 1, 4'b0111, 0, o(16'd8, 0,0,0,0,0,0,2'b00,1,0,1));
    step("to_exec3",   1, 1, 4'b0000, 0, o(16'd8, 0,0,1,0,0,0,2'b00,1,0,1));
    // Reset lands while MW is high
    rst = 1'b1;
    step("rst_in_mem", 1, 1, 4'b0000, 0, o(16'd8, 0,0,1,1,0,0,2'b00,1,0,1));
    step("rst_after",  1, 1, 4'b0000, 0, o(16'd0, 0,0,0,0,0,0,2'b00,0,0,0));
    rst = 1'b0;

    // Illegal opcode 0101 is skipped and flagged for one cycle
    doReset();
    step("il_idle",    1, 1, 4'b0000, 0, o(16'd0, 0,0,0,0,0,0,2'b00,0,0,0));
    step("il_fetch",   1, 1, 4'b0000, 0, o(16'd0, 1,1,0,0,0,0,2'b00,1,0,0));
    step("il_decode",  1, 1, 4'b0101, 0, o(16'd0, 0,0,0,0,0,0,2'b00,1,0,0));
    step("il_flag",    1, 1, 4'b0000, 0, o(16'd4, 1,1,0,0,0,0,2'b00,1,1,0));
    step("il_cleared", 1, 1, 4'b0000, 0, o(16'd4, 0,0,0,0,0,0,2'b00,1,0,0));

    // run dropped in EXEC: instruction completes then halts; FETCH ignores run
    doReset();
    step("run_idle",   1, 1, 4'b0000, 0, o(16'd0, 0,0,0,0,0,0,2'b00,0,0,0));
    step("run_fetch",  1, 1, 4'b0000, 0, o(16'd0, 1,1,0,0,0,0,2'b00,1,0,0));
    step("run_decode", 1, 1, 4'b0000, 0, o(16'd0, 0,0,0,0,0,0,2'b00,1,0,0));
    step("run_exec",   0, 1, 4'b0000, 0, o(16'd0, 0,0,0,0,1,0,2'b00,1,0,0));
    step("run_wb",     0, 1, 4'b0000, 0, o(16'd0, 0,0,0,0,1,1,2'b00,1,0,0));
    step("run_halt",   0, 1, 4'b0000, 0, o(16'd4, 0,0,0,0,0,0,2'b00,0,0,0));
    step("run_hold",   1, 0, 4'b0000, 0, o(16'd4, 0,0,0,0,0,0,2'b00,0,0,0));
    step("run_resume", 0, 0, 4'b0000, 0, o(16'd4, 1,0,0,0,0,0,2'b00,1,0,0));
    step("run_fwait",  0, 1, 4'b0000, 0, o(16'd4, 1,1,0,0,0,0,2'b00,1,0,0));
    step("run_dec2",   0, 1, 4'b0001, 0, o(16'd4, 0,0,0,0,0,0,2'b00,1,0,0));
    step("run_exec2",  0, 1, 4'b0000, 0, o(16'd4, 0,0,0,0,1,0,2'b01,1,0,0));
    step("run_wb2",    0, 1, 4'b0000, 0, o(16'd4, 0,0,0,0,1,1,2'b01,1,0,0));
    step("run_halt2",  0, 1, 4'b0000, 0, o(16'd8, 0,0,0,0,0,0,2'b00,0,0,0));

    // Walk pc to 0xFFFC with illegal opcodes (2 cycles each), then ADD wraps it
    doReset();
    applyStimulus(1'b1, 1'b1, 4'b0101, 1'b0);
    tick();
    for (int n = 0; n < 2 * 16383; n++) tick();
    step("wrap_fetch",  1, 1, 4'b0101, 0, o(16'hFFFC, 1,1,0,0,0,0,2'b00,1,1,0));
    step("wrap_decode", 1, 1, 4'b0000, 0, o(16'hFFFC, 0,0,0,0,0,0,2'b00,1,0,0));
    step("wrap_exec",   1, 1, 4'b0000, 0, o(16'hFFFC, 0,0,0,0,1,0,2'b00,1,0,0));
    step("wrap_wb",     1, 1, 4'b0000, 0, o(16'hFFFC, 0,0,0,0,1,1,2'b00,1,0,0));
    e0 = o(16'h0000, 1,1,0,0,0,0,2'b00,1,0,0);
    step("wrap_zero",   1, 1, 4'b0000, 0, e0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
